scalar_writeback_scheduler: RTL

Shares the single write port of the scalar register file between two write-back requesters: ALU (index 0) and memory-load (index 1).
Arbitration is round-robin, and the granted write is registered onto the register-file write port.
The block also keeps a per-register pending scoreboard. The decode/issue stage uses it to stall on RAW/WAW hazards until the write commits.

---
 rtl/scalar_writeback_scheduler_pkg.sv | 12 +
 rtl/scalar_writeback_scheduler_if.sv | 46 ++++
 rtl/scalar_writeback_scheduler_arbiter.sv | 32 +++
 rtl/scalar_writeback_scheduler.sv | 95 +++++++++
 4 files changed

// File: rtl/scalar_writeback_scheduler_pkg.sv
// Shared definitions for the scalar write-back scheduler slice.
package scalar_wb_pkg;

    // Write-back requester indices; the value doubles as the bit position in request/grant vectors.
    typedef enum logic {
        REQ_ALU = 1'b0,
        REQ_MEM = 1'b1
    } wbReq_t;

    localparam int NUM_WB_REQ = 2;

endpackage

// File: rtl/scalar_writeback_scheduler_if.sv
// Write-back requests, issue hazard query and register-file write port of the scheduler.
interface scalar_writeback_scheduler_if #(
    parameter int registerSize     = 16,
    parameter int registerQuantity = 4,
    parameter int selectionBits    = 2
);
    logic                        aluWbValid;
    logic [selectionBits-1:0]    aluWbReg;
    logic [registerSize-1:0]     aluWbData;
    logic                        aluWbReady;
    logic                        memWbValid;
    logic [selectionBits-1:0]    memWbReg;
    logic [registerSize-1:0]     memWbData;
    logic                        memWbReady;
    logic                        issueValid;
    logic                        issueHasDst;
    logic [selectionBits-1:0]    issueDst;
    logic                        issueUse1;
    logic                        issueUse2;
    logic [selectionBits-1:0]    rSel1;
    logic [selectionBits-1:0]    rSel2;
    logic                        issueStall;
    logic                        regWrEn;
    logic [selectionBits-1:0]    regToWrite;
    logic [registerSize-1:0]     dataIn;
    logic [registerQuantity-1:0] pending;
    logic                        wbError;

    // Scheduler side.
    modport slave (
        input  aluWbValid, aluWbReg, aluWbData,
        input  memWbValid, memWbReg, memWbData,
        input  issueValid, issueHasDst, issueDst, issueUse1, issueUse2, rSel1, rSel2,
        output aluWbReady, memWbReady, issueStall,
        output regWrEn, regToWrite, dataIn, pending, wbError
    );

    // Requester / decode / register-file side.
    modport master (
        output aluWbValid, aluWbReg, aluWbData,
        output memWbValid, memWbReg, memWbData,
        output issueValid, issueHasDst, issueDst, issueUse1, issueUse2, rSel1, rSel2,
        input  aluWbReady, memWbReady, issueStall,
        input  regWrEn, regToWrite, dataIn, pending, wbError
    );
endinterface

// File: rtl/scalar_writeback_scheduler_arbiter.sv
// Two-input round-robin arbiter: a lone request wins, a conflict goes to the requester not granted last.
module round_robin_arbiter2
    import scalar_wb_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_WB_REQ-1:0] req,
    input  logic                  updateEn,
    output logic [NUM_WB_REQ-1:0] grant
);
    wbReq_t lastGrant;

    // Grant selection from current requests and the last winner.
    always_comb begin
        grant = '0;
        if (req[REQ_ALU] && req[REQ_MEM]) begin
            if (lastGrant == REQ_MEM) grant[REQ_ALU] = 1'b1;
            else                      grant[REQ_MEM] = 1'b1;
        end else begin
            grant = req;
        end
    end

    // Remember the winner; reset favours the ALU on the first conflict.
    always_ff @(posedge clk) begin
        if (reset) begin
            lastGrant <= REQ_MEM;
        end else if (updateEn && (|grant)) begin
            lastGrant <= grant[REQ_MEM] ? REQ_MEM : REQ_ALU;
        end
    end
endmodule

// File: rtl/scalar_writeback_scheduler.sv
// Shares the scalar register-file write port between ALU and load write-back and tracks pending registers.
module scalar_writeback_scheduler
    import scalar_wb_pkg::*;
#(
    parameter int registerSize     = 16,
    parameter int registerQuantity = 4,
    parameter int selectionBits    = 2
) (
    input logic                    clk,
    input logic                    reset,
    scalar_writeback_scheduler_if.slave wb
);
    logic [NUM_WB_REQ-1:0]       req;
    logic [NUM_WB_REQ-1:0]       grant;
    logic                        regWrEn;
    logic [selectionBits-1:0]    regToWrite;
    logic [registerSize-1:0]     dataIn;
    logic [registerQuantity-1:0] pending;
    logic [registerQuantity-1:0] pendingNext;
    logic                        wbError;
    logic                        clearOfIdle;
    logic                        issueStall;
    logic                        setEn;

    assign req[REQ_ALU] = wb.aluWbValid;
    assign req[REQ_MEM] = wb.memWbValid;

    round_robin_arbiter2 arbiter (
        .clk      (clk),
        .reset    (reset),
        .req      (req),
        .updateEn (1'b1),
        .grant    (grant)
    );

    assign wb.aluWbReady = grant[REQ_ALU];
    assign wb.memWbReady = grant[REQ_MEM];
    assign wb.issueStall = issueStall;
    assign wb.regWrEn    = regWrEn;
    assign wb.regToWrite = regToWrite;
    assign wb.dataIn     = dataIn;
    assign wb.pending    = pending;
    assign wb.wbError    = wbError;

    // Hazard check: no bypass, a register on the write port this cycle still counts as pending.
    always_comb begin
        issueStall = wb.issueValid &&
                     ((wb.issueUse1   && pending[wb.rSel1]) ||
                      (wb.issueUse2   && pending[wb.rSel2]) ||
                      (wb.issueHasDst && pending[wb.issueDst]));
        setEn = wb.issueValid && wb.issueHasDst && !issueStall;
    end

    // Scoreboard next state: commit clears, issue sets; a set on the same index overrides the clear.
    always_comb begin
        pendingNext = pending;
        clearOfIdle = 1'b0;
        if (regWrEn) begin
            clearOfIdle             = !pending[regToWrite];
            pendingNext[regToWrite] = 1'b0;
        end
        if (setEn) begin
            pendingNext[wb.issueDst] = 1'b1;
        end
    end

    // Write stage: register the granted write for exactly one cycle, hold index/data otherwise.
    always_ff @(posedge clk) begin
        if (reset) begin
            regWrEn    <= 1'b0;
            regToWrite <= '0;
            dataIn     <= '0;
        end else begin
            regWrEn <= |grant;
            if (grant[REQ_ALU]) begin
                regToWrite <= wb.aluWbReg;
                dataIn     <= wb.aluWbData;
            end else if (grant[REQ_MEM]) begin
                regToWrite <= wb.memWbReg;
                dataIn     <= wb.memWbData;
            end
        end
    end

    // Scoreboard and sticky error for write-back to a register nobody was waiting on.
    always_ff @(posedge clk) begin
        if (reset) begin
            pending <= '0;
            wbError <= 1'b0;
        end else begin
            pending <= pendingNext;
            if (clearOfIdle) wbError <= 1'b1;
        end
    end
endmodule
